mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous 16-bit memory between the processor's instruction-fetch port and data-memory port.
- Sits between the pipelined core and a unified memory macro.
- Grants one access per cycle: data side by default, instruction side after a bounded wait.
- Returns read data one cycle after grant and drives a stall for the losing requester.

---
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the core-side request/response signals and the unified memory
// macro signals of the instruction/data memory port arbiter.
//   slave  : view used by the arbiter (takes core requests, drives memory).
//   master : view used by the environment (core pipeline + memory macro).
// Signals:
//   im_rd/im_addr                       instruction read request
//   im_stall/im_valid/im_r_data         instruction stall and response
//   dm_rd/dm_wr/dm_addr/dm_w_data       data read/write request
//   dm_stall/dm_valid/dm_r_data         data stall and response
//   mem_en/mem_we/mem_addr/mem_w_data   memory command (address ADDR_WIDTH+1)
//   mem_r_data                          memory read data, one cycle after read
//   arb_err                             sticky illegal-request flag
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  im_rd;
  logic [ADDR_WIDTH-1:0] im_addr;
  logic                  im_stall;
  logic                  im_valid;
  logic [DATA_WIDTH-1:0] im_r_data;

  logic                  dm_rd;
  logic                  dm_wr;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_w_data;
  logic                  dm_stall;
  logic                  dm_valid;
  logic [DATA_WIDTH-1:0] dm_r_data;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH:0]   mem_addr;
  logic [DATA_WIDTH-1:0] mem_w_data;
  logic [DATA_WIDTH-1:0] mem_r_data;

  logic                  arb_err;

  modport slave (
    input  im_rd, im_addr, dm_rd, dm_wr, dm_addr, dm_w_data, mem_r_data,
    output im_stall, im_valid, im_r_data, dm_stall, dm_valid, dm_r_data,
           mem_en, mem_we, mem_addr, mem_w_data, arb_err
  );

  modport master (
    output im_rd, im_addr, dm_rd, dm_wr, dm_addr, dm_w_data, mem_r_data,
    input  im_stall, im_valid, im_r_data, dm_stall, dm_valid, dm_r_data,
           mem_en, mem_we, mem_addr, mem_w_data, arb_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port synchronous memory between the instruction-fetch (IM)
// and data (DM) ports of a pipelined core. One access is granted per cycle:
// DM wins by default, IM wins once it has been denied MAX_STARVE cycles in a
// row. Read data returns one cycle after the grant; the loser sees a stall.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active-low
//   bus   : mem_port_arbiter_if.slave (core requests/responses, memory command)
//   perf_im_stall_cnt / perf_dm_stall_cnt / perf_conflict_cnt :
//           16-bit saturating event counters, present only when the macro
//           ARB_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_STARVE = 3   // legal range 1..15
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_port_arbiter_if.slave     bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]           perf_im_stall_cnt,
  output logic [15:0]           perf_dm_stall_cnt,
  output logic [15:0]           perf_conflict_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // nothing issued last cycle
    IM_RD = 2'd1,  // IM read in flight
    DM_RD = 2'd2,  // DM read in flight
    DM_WR = 2'd3   // DM write issued, no response
  } state_e;

  localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

  state_e                state_q, state_d;
  logic [3:0]            starve_q, starve_d;
  logic [DATA_WIDTH-1:0] im_data_q, im_data_d;
  logic [DATA_WIDTH-1:0] dm_data_q, dm_data_d;
  logic                  arb_err_q, arb_err_d;

  logic dm_req;
  logic im_grant;
  logic dm_grant;
  logic im_stall;
  logic dm_stall;

  // Issue side. Grants are suppressed while rst is low so every output is 0
  // during reset, even with requests still asserted by the core.
  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first; a path that leaves a signal unassigned infers a latch.
  always_comb begin
    dm_req   = bus.dm_rd | bus.dm_wr;
    im_grant = 1'b0;
    dm_grant = 1'b0;
    if (rst) begin
      if (bus.im_rd && (!dm_req || starve_q == STARVE_LIMIT)) begin
        im_grant = 1'b1;
      end else if (dm_req) begin
        dm_grant = 1'b1;
      end
    end
    im_stall = rst & bus.im_rd & ~im_grant;
    dm_stall = rst & dm_req & ~dm_grant;
  end

  // Memory command follows the granted port; rd+wr together counts as a write.
  always_comb begin
    bus.mem_en     = im_grant | dm_grant;
    bus.mem_we     = dm_grant & bus.dm_wr;
    bus.mem_addr   = '0;
    bus.mem_w_data = '0;
    if (im_grant) begin
      bus.mem_addr = {1'b0, bus.im_addr};
    end else if (dm_grant) begin
      bus.mem_addr = {1'b1, bus.dm_addr};
      if (bus.dm_wr) begin
        bus.mem_w_data = bus.dm_w_data;
      end
    end
    bus.im_stall = im_stall;
    bus.dm_stall = dm_stall;
  end

  // Next state: in-flight access tracking, starvation counter, responses.
  always_comb begin
    state_d = IDLE;
    if (im_grant) begin
      state_d = IM_RD;
    end else if (dm_grant) begin
      state_d = bus.dm_wr ? DM_WR : DM_RD;
    end

    starve_d = starve_q;
    if (!bus.im_rd || im_grant) begin
      starve_d = '0;
    end else if (im_stall && starve_q != STARVE_LIMIT) begin
      starve_d = starve_q + 4'd1;
    end

    arb_err_d = arb_err_q | (bus.dm_rd & bus.dm_wr);

    // Read data is presented straight from the memory in the response cycle
    // and held afterwards, so the capture registers only load on a valid.
    im_data_d = im_data_q;
    dm_data_d = dm_data_q;
    if (state_q == IM_RD) im_data_d = bus.mem_r_data;
    if (state_q == DM_RD) dm_data_d = bus.mem_r_data;

    bus.im_valid  = (state_q == IM_RD);
    bus.dm_valid  = (state_q == DM_RD);
    bus.im_r_data = bus.im_valid ? bus.mem_r_data : im_data_q;
    bus.dm_r_data = bus.dm_valid ? bus.mem_r_data : dm_data_q;
    bus.arb_err   = arb_err_q;
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values; the data hold registers are plain flops, so resetting
  // them is cheap and keeps the response outputs at 0 after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      im_data_q <= '0;
      dm_data_q <= '0;
      arb_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      im_data_q <= im_data_d;
      dm_data_q <= dm_data_d;
      arb_err_q <= arb_err_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [15:0] perf_im_q, perf_im_d;
  logic [15:0] perf_dm_q, perf_dm_d;
  logic [15:0] perf_cf_q, perf_cf_d;

  // Saturating event counters; a conflict is both ports requesting at once.
  always_comb begin
    perf_im_d = perf_im_q;
    perf_dm_d = perf_dm_q;
    perf_cf_d = perf_cf_q;
    if (im_stall && perf_im_q != 16'hFFFF) perf_im_d = perf_im_q + 16'd1;
    if (dm_stall && perf_dm_q != 16'hFFFF) perf_dm_d = perf_dm_q + 16'd1;
    if (rst && bus.im_rd && dm_req && perf_cf_q != 16'hFFFF) begin
      perf_cf_d = perf_cf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_im_q <= '0;
      perf_dm_q <= '0;
      perf_cf_q <= '0;
    end else begin
      perf_im_q <= perf_im_d;
      perf_dm_q <= perf_dm_d;
      perf_cf_q <= perf_cf_d;
    end
  end

  assign perf_im_stall_cnt = perf_im_q;
  assign perf_dm_stall_cnt = perf_dm_q;
  assign perf_conflict_cnt = perf_cf_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a behavioural 512x16 synchronous
// memory. Stimulus pushes expected read data into per-port queues; a monitor
// pops and compares whenever the DUT raises im_valid or dm_valid. Issue-side
// signals are checked directly in the cycle they are driven.
// Define ARB_PERF_CNT_EN to include the performance counter checks.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

`ifdef ARB_PERF_CNT_EN
  logic [15:0] perf_im_stall_cnt, perf_dm_stall_cnt, perf_conflict_cnt;
`endif

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_STARVE(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_im_stall_cnt (perf_im_stall_cnt),
    .perf_dm_stall_cnt (perf_dm_stall_cnt),
    .perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  // Behavioural single-port synchronous memory.
  logic [DW-1:0] mem [0:511];
  always @(posedge clk) begin
    if (bus_if.mem_en) begin
      if (bus_if.mem_we) mem[bus_if.mem_addr] <= bus_if.mem_w_data;
      else               bus_if.mem_r_data    <= mem[bus_if.mem_addr];
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b1;
  logic [DW-1:0] im_exp_q [$];
  logic [DW-1:0] dm_exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every response against the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1 && mon_en) begin
      if (bus_if.im_valid === 1'b1) begin
        if (im_exp_q.size() == 0) check("im_valid_unexpected", 32'(bus_if.im_valid), 32'd0);
        else                      check("im_r_data", 32'(bus_if.im_r_data), 32'(im_exp_q.pop_front()));
      end
      if (bus_if.dm_valid === 1'b1) begin
        if (dm_exp_q.size() == 0) check("dm_valid_unexpected", 32'(bus_if.dm_valid), 32'd0);
        else                      check("dm_r_data", 32'(bus_if.dm_r_data), 32'(dm_exp_q.pop_front()));
      end
    end
  end

  // Step to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.im_rd     = 1'b0;
    bus_if.im_addr   = '0;
    bus_if.dm_rd     = 1'b0;
    bus_if.dm_wr     = 1'b0;
    bus_if.dm_addr   = '0;
    bus_if.dm_w_data = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] im_win_pat;
    im_win_pat = 8'b1000_1000;  // bit i: IM expected to win in conflict cycle i

    for (int i = 0; i < 512; i++) mem[i] <= '0;
    mem[9'h005] <= 16'hA1B2;
    mem[9'h007] <= 16'h7777;
    mem[9'h120] <= 16'h2020;

    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    // Reset state with no requests.
    check("rst_mem_en",    32'(bus_if.mem_en),    32'd0);
    check("rst_im_valid",  32'(bus_if.im_valid),  32'd0);
    check("rst_dm_valid",  32'(bus_if.dm_valid),  32'd0);
    check("rst_im_r_data", 32'(bus_if.im_r_data), 32'd0);
    check("rst_dm_r_data", 32'(bus_if.dm_r_data), 32'd0);
    check("rst_arb_err",   32'(bus_if.arb_err),   32'd0);
    check("rst_mem_addr",  32'(bus_if.mem_addr),  32'd0);

    // Lone IM read at 0x05.
    cyc();
    bus_if.im_rd = 1'b1; bus_if.im_addr = 8'h05;
    #1;
    check("im_mem_addr", 32'(bus_if.mem_addr), 32'h005);
    check("im_stall",    32'(bus_if.im_stall), 32'd0);
    check("im_mem_en",   32'(bus_if.mem_en),   32'd1);
    check("im_mem_we",   32'(bus_if.mem_we),   32'd0);
    im_exp_q.push_back(16'hA1B2);

    // DM write 0x1234 to 0x10 while the IM response returns.
    cyc();
    idle_inputs();
    bus_if.dm_wr = 1'b1; bus_if.dm_addr = 8'h10; bus_if.dm_w_data = 16'h1234;
    #1;
    check("wr_mem_addr",   32'(bus_if.mem_addr),   32'h110);
    check("wr_mem_we",     32'(bus_if.mem_we),     32'd1);
    check("wr_mem_w_data", 32'(bus_if.mem_w_data), 32'h1234);
    check("wr_dm_stall",   32'(bus_if.dm_stall),   32'd0);

    // DM read back from 0x10.
    cyc();
    idle_inputs();
    bus_if.dm_rd = 1'b1; bus_if.dm_addr = 8'h10;
    #1;
    check("rd_mem_addr",   32'(bus_if.mem_addr),   32'h110);
    check("rd_mem_we",     32'(bus_if.mem_we),     32'd0);
    check("rd_mem_w_data", 32'(bus_if.mem_w_data), 32'd0);
    check("wr_no_dm_valid", 32'(bus_if.dm_valid),  32'd0);
    check("im_r_data_held", 32'(bus_if.im_r_data), 32'hA1B2);
    dm_exp_q.push_back(16'h1234);

    cyc();
    idle_inputs();
    cyc();
    #1;
    check("dm_r_data_held", 32'(bus_if.dm_r_data), 32'h1234);
    check("dm_valid_low",   32'(bus_if.dm_valid),  32'd0);

    // Continuous conflict: DM,DM,DM,IM repeating.
    for (int i = 0; i < 8; i++) begin
      cyc();
      bus_if.im_rd = 1'b1; bus_if.im_addr = 8'h07;
      bus_if.dm_rd = 1'b1; bus_if.dm_addr = 8'h20;
      #1;
      check($sformatf("conf_im_stall_%0d", i), 32'(bus_if.im_stall), 32'(!im_win_pat[i]));
      check($sformatf("conf_dm_stall_%0d", i), 32'(bus_if.dm_stall), 32'(im_win_pat[i]));
      check($sformatf("conf_mem_addr_%0d", i), 32'(bus_if.mem_addr),
            im_win_pat[i] ? 32'h007 : 32'h120);
      if (im_win_pat[i]) im_exp_q.push_back(16'h7777);
      else               dm_exp_q.push_back(16'h2020);
    end
    cyc();
    idle_inputs();

    // dm_rd and dm_wr together: write, no response, sticky error.
    cyc();
    bus_if.dm_rd = 1'b1; bus_if.dm_wr = 1'b1;
    bus_if.dm_addr = 8'h30; bus_if.dm_w_data = 16'hBEEF;
    #1;
    check("err_mem_we",     32'(bus_if.mem_we),     32'd1);
    check("err_mem_addr",   32'(bus_if.mem_addr),   32'h130);
    check("err_mem_w_data", 32'(bus_if.mem_w_data), 32'hBEEF);
    check("err_before",     32'(bus_if.arb_err),    32'd0);
    cyc();
    idle_inputs();
    #1;
    check("err_set",        32'(bus_if.arb_err),    32'd1);
    check("err_no_dm_valid", 32'(bus_if.dm_valid),  32'd0);
    cyc();
    bus_if.dm_rd = 1'b1; bus_if.dm_addr = 8'h30;
    dm_exp_q.push_back(16'hBEEF);
    cyc();
    idle_inputs();
    cyc();
    #1;
    check("err_sticky", 32'(bus_if.arb_err), 32'd1);

    // Asynchronous reset while an IM read is in flight.
    cyc();
    bus_if.im_rd = 1'b1; bus_if.im_addr = 8'h05;
    cyc();
    bus_if.dm_rd = 1'b1; bus_if.dm_addr = 8'h20;
    #1 rst = 1'b0;
    #1;
    check("arst_im_valid", 32'(bus_if.im_valid), 32'd0);
    check("arst_im_r_data", 32'(bus_if.im_r_data), 32'd0);
    check("arst_mem_en",   32'(bus_if.mem_en),   32'd0);
    check("arst_im_stall", 32'(bus_if.im_stall), 32'd0);
    check("arst_dm_stall", 32'(bus_if.dm_stall), 32'd0);
    check("arst_arb_err",  32'(bus_if.arb_err),  32'd0);
    cyc();
    idle_inputs();
    rst = 1'b1;
    cyc();
    #1;
    check("post_rst_im_valid", 32'(bus_if.im_valid), 32'd0);
    check("post_rst_dm_valid", 32'(bus_if.dm_valid), 32'd0);

`ifdef ARB_PERF_CNT_EN
    // Performance counters: 10 conflict cycles, then saturate the conflict count.
    mon_en = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      bus_if.im_rd = 1'b1; bus_if.im_addr = 8'h07;
      bus_if.dm_wr = 1'b1; bus_if.dm_addr = 8'h40; bus_if.dm_w_data = 16'h0001;
    end
    cyc();
    idle_inputs();
    #1;
    check("perf_conflict_10", 32'(perf_conflict_cnt), 32'd10);
    check("perf_im_stall_8",  32'(perf_im_stall_cnt), 32'd8);
    check("perf_dm_stall_2",  32'(perf_dm_stall_cnt), 32'd2);
    bus_if.im_rd = 1'b1; bus_if.dm_wr = 1'b1;
    repeat (66000) @(posedge clk);
    #1;
    idle_inputs();
    #1;
    check("perf_conflict_sat", 32'(perf_conflict_cnt), 32'hFFFF);
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    mon_en = 1'b1;
`endif

    repeat (2) cyc();
    check("im_queue_drained", 32'(im_exp_q.size()), 32'd0);
    check("dm_queue_drained", 32'(dm_exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
